// File: rtl/fnn_pkg.sv
// Shared definitions for the feed-forward network stream blocks.
package fnn_pkg;

  localparam int DATA_WIDTH_DEFAULT  = 16;
  localparam int NUM_NEURONS_DEFAULT = 10;
  localparam int MIN_GAP_DEFAULT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_GAP
  } stream_state_t;

endpackage

// File: rtl/layer_out_streamer_if.sv
// Parallel capture side and serial stream side of the layer output streamer.
interface layer_out_streamer_if #(
  parameter int NUM_NEURONS = fnn_pkg::NUM_NEURONS_DEFAULT,
  parameter int DATA_WIDTH  = fnn_pkg::DATA_WIDTH_DEFAULT
);

  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
  logic [NUM_NEURONS-1:0]            in_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              busy;
  logic                              burst_done;
  logic                              overrun;

  // Streamer view: takes neuron results, produces the serial burst and status.
  modport slave (
    input  in_data,
    input  in_valid,
    output out_data,
    output out_valid,
    output busy,
    output burst_done,
    output overrun
  );

  // Environment view: feeds neuron results, watches the stream.
  modport master (
    output in_data,
    output in_valid,
    input  out_data,
    input  out_valid,
    input  busy,
    input  burst_done,
    input  overrun
  );

endinterface

// File: rtl/layer_capture_bank.sv
// Holding bank for one full set of neuron results. Each lane is captured once
// per set; a second arrival on an already captured lane is flagged and dropped.
module layer_capture_bank
  import fnn_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEFAULT,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  input  logic                              clear,
  output logic                              full,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] bank,
  output logic                              dup
);

  logic [NUM_NEURONS-1:0] cap;

  assign full = &cap;

  // While the bank is being handed over, every lane counts as empty, so lanes
  // arriving in that cycle start the next set instead of being flagged.
  assign dup = (|(in_valid & cap)) & ~clear;

  // Capture each lane the first time it shows up in the current set.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap  <= '0;
      bank <= '0;
    end else begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (in_valid[k] && (clear || !cap[k])) begin
          bank[k*DATA_WIDTH +: DATA_WIDTH] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      cap <= (clear ? '0 : cap) | in_valid;
    end
  end

endmodule

// File: rtl/layer_out_streamer.sv
// Captures one layer's parallel neuron outputs and replays them, lane 0 first,
// as a contiguous serial burst for the next layer. A new set may be collected
// in the holding bank while the previous one streams from its own buffer.
module layer_out_streamer
  import fnn_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEFAULT,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int MIN_GAP     = MIN_GAP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_out_streamer_if.slave  bus
);

  localparam int BEAT_W = $clog2(NUM_NEURONS);
  localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_NEURONS - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  stream_state_t state, state_next;

  logic [NUM_NEURONS*DATA_WIDTH-1:0] bank;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] stream_buf;
  logic [BEAT_W-1:0]                 beat;
  logic [GAP_W-1:0]                  gap_cnt;
  logic                              full;
  logic                              dup;
  logic                              transfer;
  logic                              last_beat;
  logic                              burst_done_r;
  logic                              overrun_r;

  layer_capture_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .in_data  (bus.in_data),
    .in_valid (bus.in_valid),
    .clear    (transfer),
    .full     (full),
    .bank     (bank),
    .dup      (dup)
  );

  // Decide when a full bank moves into the stream buffer and when a burst or gap ends.
  always_comb begin
    state_next = state;
    transfer   = 1'b0;
    last_beat  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full) begin
          transfer   = 1'b1;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (beat == LAST_BEAT) begin
          last_beat  = 1'b1;
          state_next = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == LAST_GAP) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; a reset anywhere in a burst drops straight back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stream buffer, beat/gap counters and the status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      stream_buf   <= '0;
      beat         <= '0;
      gap_cnt      <= '0;
      burst_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (transfer) begin
        stream_buf <= bank;
        beat       <= '0;
      end else if (state == ST_STREAM) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end
      if (state == ST_GAP && gap_cnt != LAST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
      burst_done_r <= last_beat;
      overrun_r    <= overrun_r | dup;
    end
  end

  assign bus.out_valid  = (state == ST_STREAM);
  assign bus.out_data   = (state == ST_STREAM) ? stream_buf[int'(beat)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.burst_done = burst_done_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_layer_out_streamer.sv
// Testbench for layer_out_streamer: two instances (gap 8 and gap 0) share one
// stimulus stream and are compared every cycle against a schedule-based model.
module tb_layer_out_streamer;
  import fnn_pkg::*;

  localparam int N   = 10;
  localparam int DW  = 16;
  localparam int KEY = 100000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  layer_out_streamer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) bus0 ();
  layer_out_streamer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) bus1 ();

  layer_out_streamer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .MIN_GAP(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  layer_out_streamer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .MIN_GAP(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: holding set per instance plus a per-cycle schedule of expected outputs.
  logic [DW-1:0] m_hold [2][N];
  logic [N-1:0]  m_cap [2];
  logic          m_ovr [2];
  int            m_next_idle [2];
  logic [DW-1:0] exp_data [int];
  bit            exp_busy [int];
  bit            exp_done [int];

  function automatic int gap_of(input int d);
    return (d == 0) ? 8 : 0;
  endfunction

  function automatic logic [N*DW-1:0] randData();
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  // Compare both instances with what the schedule predicts for the current cycle.
  task automatic checkOutput();
    for (int d = 0; d < 2; d++) begin
      int key;
      logic [DW-1:0] o_data;
      logic o_valid, o_busy, o_done, o_ovr;
      logic [DW-1:0] e_data;
      key = d*KEY + cyc;
      if (d == 0) begin
        o_data = bus0.out_data; o_valid = bus0.out_valid; o_busy = bus0.busy;
        o_done = bus0.burst_done; o_ovr = bus0.overrun;
      end else begin
        o_data = bus1.out_data; o_valid = bus1.out_valid; o_busy = bus1.busy;
        o_done = bus1.burst_done; o_ovr = bus1.overrun;
      end
      e_data = exp_data.exists(key) ? exp_data[key] : '0;
      check1($sformatf("dut%0d.out_valid", d), 32'(o_valid), 32'(exp_data.exists(key)));
      check1($sformatf("dut%0d.out_data", d), 32'(o_data), 32'(e_data));
      check1($sformatf("dut%0d.busy", d), 32'(o_busy), 32'(exp_busy.exists(key)));
      check1($sformatf("dut%0d.burst_done", d), 32'(o_done), 32'(exp_done.exists(key)));
      check1($sformatf("dut%0d.overrun", d), 32'(o_ovr), 32'(m_ovr[d]));
    end
  endtask

  // Advance the model by one cycle given this cycle's inputs.
  task automatic modelStep(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] dat);
    for (int d = 0; d < 2; d++) begin
      int g;
      g = gap_of(d);
      if (r) begin
        m_cap[d]       = '0;
        m_ovr[d]       = 1'b0;
        m_next_idle[d] = cyc + 1;
        for (int x = cyc + 1; x <= cyc + 40; x++) begin
          exp_data.delete(d*KEY + x);
          exp_busy.delete(d*KEY + x);
          exp_done.delete(d*KEY + x);
        end
      end else begin
        if (m_cap[d] == '1 && cyc >= m_next_idle[d]) begin
          for (int b = 0; b < N; b++) exp_data[d*KEY + cyc + 1 + b] = m_hold[d][b];
          for (int x = cyc + 1; x <= cyc + N + g; x++) exp_busy[d*KEY + x] = 1'b1;
          exp_done[d*KEY + cyc + N + 1] = 1'b1;
          m_next_idle[d] = cyc + N + g + 1;
          m_cap[d]       = '0;
        end
        for (int k = 0; k < N; k++) begin
          if (v[k]) begin
            if (m_cap[d][k]) begin
              m_ovr[d] = 1'b1;
            end else begin
              m_hold[d][k]  = dat[k*DW +: DW];
              m_cap[d][k]   = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, update the model.
  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] dat);
    rst           = r;
    bus0.in_valid = v;
    bus1.in_valid = v;
    bus0.in_data  = dat;
    bus1.in_data  = dat;
    @(negedge clk);
    checkOutput();
    modelStep(r, v, dat);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0);
  endtask

  // Deliver one full set with lanes arriving in random groups over several cycles.
  task automatic scatterSet();
    logic [N-1:0] rem, v;
    int guard;
    rem   = '1;
    guard = 0;
    while (rem != '0) begin
      v = rem & N'($urandom);
      guard++;
      if (guard > 20) v = rem;
      applyStimulus(1'b0, v, randData());
      rem &= ~v;
    end
  endtask

  initial begin
    logic [N*DW-1:0] dat;
    logic [N-1:0]    v;

    for (int d = 0; d < 2; d++) begin
      m_cap[d] = '0; m_ovr[d] = 1'b0; m_next_idle[d] = 0;
      for (int k = 0; k < N; k++) m_hold[d][k] = '0;
    end
    rst = 1'b1;
    bus0.in_valid = '0; bus1.in_valid = '0;
    bus0.in_data  = '0; bus1.in_data  = '0;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    applyStimulus(1'b1, '0, '0);
    idle(2);

    $display("[TB] all lanes in one cycle, lane k = 0100+k");
    for (int k = 0; k < N; k++) dat[k*DW +: DW] = 16'h0100 + DW'(k);
    applyStimulus(1'b0, '1, dat);
    idle(25);

    $display("[TB] lanes one per cycle, 9 down to 0");
    dat = randData();
    for (int k = N - 1; k >= 0; k--) begin
      v = '0;
      v[k] = 1'b1;
      applyStimulus(1'b0, v, dat);
    end
    idle(25);

    $display("[TB] second set collected during first burst");
    applyStimulus(1'b0, '1, randData());
    idle(2);
    scatterSet();
    idle(40);

    $display("[TB] duplicate on lane 3");
    dat = randData();
    dat[3*DW +: DW] = 16'h8000;
    applyStimulus(1'b0, 10'b0000001000, dat);
    applyStimulus(1'b0, 10'b0000000111, randData());
    dat = randData();
    dat[3*DW +: DW] = 16'h7FFF;
    applyStimulus(1'b0, 10'b1111111000, dat);
    idle(25);

    $display("[TB] reset at beat 4");
    applyStimulus(1'b0, '1, randData());
    idle(5);
    applyStimulus(1'b1, '0, '0);
    idle(3);
    applyStimulus(1'b0, '1, randData());
    idle(25);

    $display("[TB] back-to-back sets, second arrives in transfer cycle");
    applyStimulus(1'b0, '1, randData());
    applyStimulus(1'b0, '1, randData());
    idle(40);

    $display("[TB] random scattered sets");
    repeat (8) begin
      scatterSet();
      idle($urandom_range(0, 15));
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
